// File: rtl/img_buffer_ctl.sv
// Frame-level write scheduler for the reference image buffer: decides per frame
// whether the buffer is overwritten, drives its write gate and tracks validity.
module img_buffer_ctl #(
    parameter int    FRAME_CNT_BITS = 16,
    parameter int    SKIP_BITS      = 8,
    parameter string DEBUG          = "false"
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic                      cke,
    input  logic                      s_valid,
    input  logic                      s_row_first,
    input  logic                      s_row_last,
    input  logic                      s_col_first,
    input  logic                      s_col_last,
    input  logic                      s_de,
    input  logic [1:0]                cfg_mode,
    input  logic [SKIP_BITS-1:0]      cfg_skip,
    input  logic                      cfg_shot,
    output logic                      wr_enable,
    output logic                      ref_valid,
    output logic                      frame_active,
    output logic                      shot_busy,
    output logic [FRAME_CNT_BITS-1:0] frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_SKIP  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CONT   = 2'd0;
    localparam logic [1:0] MODE_DECIM  = 2'd1;
    localparam logic [1:0] MODE_SHOT   = 2'd2;
    localparam logic [SKIP_BITS-1:0]      SKIP_ONE = 1;
    localparam logic [FRAME_CNT_BITS-1:0] CNT_ONE  = 1;

    state_t                      state_q, state_d, decision;
    logic                        armed_q, armed_d;
    logic [SKIP_BITS-1:0]        skip_cnt_q, skip_cnt_d;
    logic                        shot_frame_q, shot_frame_d;
    logic                        ref_valid_q, ref_valid_d;
    logic [FRAME_CNT_BITS-1:0]   frame_count_q, frame_count_d;
    logic                        wr_enable_q, wr_enable_d;
    logic                        frame_active_q, frame_active_d;
    logic                        shot_busy_q, shot_busy_d;
    logic                        start_beat, end_beat, shot_req;
    logic                        unused_debug;

    assign unused_debug = (DEBUG == "true");

    assign start_beat = s_valid & s_row_first & s_col_first;
    assign end_beat   = s_valid & s_de & s_row_last & s_col_last;
    // A shot pulse landing on the start beat counts for that very frame.
    assign shot_req   = armed_q | cfg_shot;

    always_comb begin
        decision = ST_SKIP;
        case (cfg_mode)
            MODE_CONT:  decision = ST_STORE;
            MODE_DECIM: if (skip_cnt_q == '0) decision = ST_STORE;
            MODE_SHOT:  if (shot_req) decision = ST_STORE;
            default:    decision = ST_SKIP;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q | cfg_shot;
        skip_cnt_d    = skip_cnt_q;
        shot_frame_d  = shot_frame_q;
        ref_valid_d   = ref_valid_q;
        frame_count_d = frame_count_q;

        if (start_beat) begin
            state_d      = decision;
            shot_frame_d = (cfg_mode == MODE_SHOT);
            if (state_q == ST_STORE) begin
                ref_valid_d = 1'b0;
            end
            if (cfg_mode == MODE_DECIM) begin
                skip_cnt_d = (decision == ST_STORE) ? cfg_skip : skip_cnt_q - SKIP_ONE;
            end else begin
                skip_cnt_d = '0;
            end
            if ((cfg_mode == MODE_SHOT) && (decision == ST_STORE)) begin
                armed_d = 1'b0;
            end
        end

        // The end beat itself is still written, so the gate is taken before completion.
        wr_enable_d = (state_d == ST_STORE);

        if (end_beat && (state_d != ST_IDLE)) begin
            if (state_d == ST_STORE) begin
                frame_count_d = frame_count_q + CNT_ONE;
                ref_valid_d   = 1'b1;
            end
            state_d = ST_IDLE;
        end

        frame_active_d = (state_d != ST_IDLE);
        shot_busy_d    = armed_d | ((state_d == ST_STORE) & shot_frame_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            armed_q        <= 1'b0;
            skip_cnt_q     <= '0;
            shot_frame_q   <= 1'b0;
            ref_valid_q    <= 1'b0;
            frame_count_q  <= '0;
            wr_enable_q    <= 1'b0;
            frame_active_q <= 1'b0;
            shot_busy_q    <= 1'b0;
        end else if (cke) begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            skip_cnt_q     <= skip_cnt_d;
            shot_frame_q   <= shot_frame_d;
            ref_valid_q    <= ref_valid_d;
            frame_count_q  <= frame_count_d;
            wr_enable_q    <= wr_enable_d;
            frame_active_q <= frame_active_d;
            shot_busy_q    <= shot_busy_d;
        end
    end

    assign wr_enable    = wr_enable_q;
    assign ref_valid    = ref_valid_q;
    assign frame_active = frame_active_q;
    assign shot_busy    = shot_busy_q;
    assign frame_count  = frame_count_q;

endmodule
